// File: rtl/drone_pkg.sv
// Shared constants and encodings for the drone level sequencer.
package drone_pkg;

    localparam int unsigned NIVEL_W  = 2;
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = 2'b11;

    localparam int unsigned ESTADO_W = 3;
    typedef logic [ESTADO_W-1:0] estado_t;

    localparam estado_t ST_INIT         = 3'd0;
    localparam estado_t ST_IDLE         = 3'd1;
    localparam estado_t ST_EXEC         = 3'd2;
    localparam estado_t ST_HOLD         = 3'd3;
    localparam estado_t ST_EMERG_DESCE  = 3'd4;
    localparam estado_t ST_EMERG_ESPERA = 3'd5;
    localparam estado_t ST_POUSADO      = 3'd6;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_SOBE  = 2'd1,
        CMD_DESCE = 2'd2,
        CMD_LOAD  = 2'd3
    } cmd_e;

    // Larger of two unsigned values, used to size the shared wait counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/drone_temporizador.sv
// Loadable down-counter with zero flag, shared by the hold-off and descent waits.
module drone_temporizador #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_c_o
);

    logic [W-1:0] cnt_q;

    // Reload wins over counting; the counter parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/drone_nivel_controlador.sv
// Request arbiter and command sequencer for the drone's 2-bit level counter.
module drone_nivel_controlador
    import drone_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned DESCE_CYCLES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               emerg,
    input  logic               preset_req,
    input  logic [NIVEL_W-1:0] preset_val,
    input  logic               sobe_req,
    input  logic               desce_req,
    input  logic [NIVEL_W-1:0] nivel,
    output logic               ctr_clr,
    output logic               ctr_ld,
    output logic [NIVEL_W-1:0] ctr_D,
    output logic               ctr_enp,
    output logic               ctr_soma,
    output logic               ctr_sub,
    output logic               ack,
    output logic               rejeitado,
    output logic               ocupado,
    output logic               pousado,
    output logic [ESTADO_W-1:0] estado
);

    localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, DESCE_CYCLES);
    localparam int unsigned TMR_W   = $clog2(CNT_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_RELOAD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] DESCE_RELOAD = TMR_W'(DESCE_CYCLES - 1);

    estado_t            state_q, state_d;
    cmd_e               cmd_c;
    logic               rej_d;
    logic               tmr_load_c, tmr_en_c, tmr_zero_c;
    logic [TMR_W-1:0]   tmr_val_c;
    estado_t            emerg_dest_c;

    logic               ctr_clr_d, ctr_ld_d, ctr_enp_d, ctr_soma_d, ctr_sub_d;
    logic               ack_d, ocupado_d, pousado_d;
    logic [NIVEL_W-1:0] ctr_d_d;

    drone_temporizador #(.W(TMR_W)) u_temporizador (
        .clk        (clock),
        .rst        (reset),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .en_i       (tmr_en_c),
        .zero_c_o   (tmr_zero_c)
    );

    // Next state, request arbitration and Moore output decode of the next state.
    always_comb begin
        state_d      = state_q;
        cmd_c        = CMD_NONE;
        rej_d        = 1'b0;
        tmr_load_c   = 1'b0;
        tmr_val_c    = '0;
        tmr_en_c     = 1'b0;
        emerg_dest_c = (nivel != '0) ? ST_EMERG_DESCE : ST_POUSADO;

        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (emerg) begin
                    state_d = emerg_dest_c;
                end else if (preset_req) begin
                    cmd_c   = CMD_LOAD;
                    state_d = ST_EXEC;
                end else if (sobe_req && !desce_req) begin
                    if (nivel == NIVEL_MAX) begin
                        rej_d = 1'b1;
                    end else begin
                        cmd_c   = CMD_SOBE;
                        state_d = ST_EXEC;
                    end
                end else if (desce_req && !sobe_req) begin
                    if (nivel == '0) begin
                        rej_d = 1'b1;
                    end else begin
                        cmd_c   = CMD_DESCE;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d    = ST_HOLD;
                tmr_load_c = 1'b1;
                tmr_val_c  = HOLD_RELOAD;
            end
            ST_HOLD: begin
                if (emerg) begin
                    state_d = emerg_dest_c;
                end else if (tmr_zero_c) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end
            ST_EMERG_DESCE: begin
                state_d    = ST_EMERG_ESPERA;
                tmr_load_c = 1'b1;
                tmr_val_c  = DESCE_RELOAD;
            end
            ST_EMERG_ESPERA: begin
                if (tmr_zero_c) begin
                    state_d = (nivel == '0) ? ST_POUSADO : ST_EMERG_DESCE;
                end else begin
                    tmr_en_c = 1'b1;
                end
            end
            ST_POUSADO: begin
                if (!emerg) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        ctr_clr_d  = (state_d != ST_INIT);
        ctr_ld_d   = !(cmd_c == CMD_LOAD);
        ctr_d_d    = (cmd_c == CMD_LOAD) ? preset_val : '0;
        ctr_soma_d = (cmd_c == CMD_SOBE);
        ctr_sub_d  = (cmd_c == CMD_DESCE) || (state_d == ST_EMERG_DESCE);
        ctr_enp_d  = ctr_soma_d || ctr_sub_d;
        ack_d      = (state_d == ST_EXEC);
        ocupado_d  = (state_d != ST_IDLE) && (state_d != ST_POUSADO);
        pousado_d  = (state_d == ST_POUSADO);
    end

    // State and registered command/status outputs; reset parks in INIT with clear asserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            ctr_clr   <= 1'b0;
            ctr_ld    <= 1'b1;
            ctr_D     <= '0;
            ctr_enp   <= 1'b0;
            ctr_soma  <= 1'b0;
            ctr_sub   <= 1'b0;
            ack       <= 1'b0;
            rejeitado <= 1'b0;
            ocupado   <= 1'b1;
            pousado   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_clr   <= ctr_clr_d;
            ctr_ld    <= ctr_ld_d;
            ctr_D     <= ctr_d_d;
            ctr_enp   <= ctr_enp_d;
            ctr_soma  <= ctr_soma_d;
            ctr_sub   <= ctr_sub_d;
            ack       <= ack_d;
            rejeitado <= rej_d;
            ocupado   <= ocupado_d;
            pousado   <= pousado_d;
        end
    end

    assign estado = state_q;

endmodule

// File: tb/tb_drone_nivel_controlador.sv
// Self-checking bench: controller plus behavioural level counter, scoreboarded command events.
module tb_drone_nivel_controlador;

    localparam int unsigned HOLD  = 4;
    localparam int unsigned DESCE = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       emerg = 1'b0;
    logic       preset_req = 1'b0;
    logic [1:0] preset_val = 2'b00;
    logic       sobe_req = 1'b0;
    logic       desce_req = 1'b0;
    logic [1:0] nivel = 2'b00;
    logic       ctr_clr, ctr_ld, ctr_enp, ctr_soma, ctr_sub;
    logic [1:0] ctr_D;
    logic       ack, rejeitado, ocupado, pousado;
    logic [2:0] estado;

    int         checks = 0;
    int         errors = 0;
    int unsigned cyc = 0;
    logic [1:0] exp_lvl = 2'b00;
    logic [8:0] exp_q[$];

    drone_nivel_controlador #(.HOLD_CYCLES(HOLD), .DESCE_CYCLES(DESCE)) dut (
        .clock(clock), .reset(reset), .emerg(emerg),
        .preset_req(preset_req), .preset_val(preset_val),
        .sobe_req(sobe_req), .desce_req(desce_req), .nivel(nivel),
        .ctr_clr(ctr_clr), .ctr_ld(ctr_ld), .ctr_D(ctr_D), .ctr_enp(ctr_enp),
        .ctr_soma(ctr_soma), .ctr_sub(ctr_sub), .ack(ack), .rejeitado(rejeitado),
        .ocupado(ocupado), .pousado(pousado), .estado(estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Level counter: clr > ld > enp-gated soma/sub, saturating at 0 and 3.
    always @(posedge clock) begin
        if (!ctr_clr)                         nivel <= 2'b00;
        else if (!ctr_ld)                     nivel <= ctr_D;
        else if (ctr_enp && ctr_soma && nivel != 2'b11) nivel <= nivel + 2'b01;
        else if (ctr_enp && ctr_sub  && nivel != 2'b00) nivel <= nivel - 2'b01;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    wire [8:0]  obs = {ack, rejeitado, ctr_clr, ctr_ld, ctr_D, ctr_enp, ctr_soma, ctr_sub};
    wire [13:0] all_out = {estado, ctr_clr, ctr_ld, ctr_D, ctr_enp, ctr_soma, ctr_sub,
                           ack, rejeitado, ocupado, pousado};
    localparam logic [13:0] RESET_VEC = {3'd0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};

    // Monitor: every ack/rejeitado cycle must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset && (ack || rejeitado)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got ack=%0b rej=%0b, required no event (t=%0t)",
                         ack, rejeitado, $time);
            end else begin
                check("event", 32'(obs), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (estado != 3'd1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) check("wait_idle_timeout", 32'(estado), 32'd1);
    endtask

    // Issue one single-cycle request; the reference decides ack/reject/ignore from priority and level.
    task automatic req(input bit pre, input logic [1:0] pv, input bit up, input bit dn);
        bit acc = 1'b0;
        bit refu = 1'b0;
        logic [8:0] ev = '0;
        wait_idle();
        if (pre) begin
            acc = 1'b1; ev = {1'b1, 1'b0, 1'b1, 1'b0, pv, 3'b000}; exp_lvl = pv;
        end else if (up && !dn) begin
            if (exp_lvl == 2'd3) refu = 1'b1;
            else begin acc = 1'b1; ev = {4'b1011, 2'b00, 3'b110}; exp_lvl = exp_lvl + 2'd1; end
        end else if (dn && !up) begin
            if (exp_lvl == 2'd0) refu = 1'b1;
            else begin acc = 1'b1; ev = {4'b1011, 2'b00, 3'b101}; exp_lvl = exp_lvl - 2'd1; end
        end
        if (refu) ev = {4'b0111, 2'b00, 3'b000};
        if (acc || refu) exp_q.push_back(ev);
        preset_req = pre; preset_val = pv; sobe_req = up; desce_req = dn;
        @(negedge clock);
        preset_req = 1'b0; preset_val = 2'b00; sobe_req = 1'b0; desce_req = 1'b0;
        if (acc) begin
            wait_idle();
        end else begin
            check("stay_idle", 32'(estado), 32'd1);
            @(negedge clock);
        end
        check("nivel", 32'(nivel), 32'(exp_lvl));
    endtask

    // Emergency descent from lvl0: pulse count, spacing, landing and exit to IDLE.
    task automatic emerg_run(input int lvl0, input bit drop_early);
        int pulses = 0;
        int n = 0;
        int unsigned t0;
        int unsigned prev = 0;
        t0 = cyc;
        emerg = 1'b1;
        while (!pousado && n < 300) begin
            @(negedge clock);
            n++;
            if (ctr_enp && ctr_sub) begin
                if (pulses == 0) check("emerg_first_delay", cyc - t0, 32'd1);
                else             check("emerg_spacing", cyc - prev, DESCE + 1);
                prev = cyc;
                pulses++;
                if (drop_early) emerg = 1'b0;
            end
        end
        if (n >= 300) check("emerg_timeout", 32'(pousado), 32'd1);
        check("emerg_pulses", 32'(pulses), 32'(lvl0));
        check("landed_nivel", 32'(nivel), 32'd0);
        check("landed_estado", 32'(estado), 32'd6);
        if (emerg) begin
            @(negedge clock);
            check("pousado_holds", 32'(pousado), 32'd1);
            emerg = 1'b0;
        end
        @(negedge clock);
        check("exit_idle", 32'(estado), 32'd1);
        check("exit_pousado_low", 32'(pousado), 32'd0);
        exp_lvl = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] pv;
        // Reset values and counter clearing while reset is held
        repeat (2) @(negedge clock);
        check("reset_outputs", 32'(all_out), 32'(RESET_VEC));
        check("reset_clears_nivel", 32'(nivel), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", 32'(estado), 32'd1);

        // Single sobe from level 0: one ack/command cycle, busy for 1+HOLD cycles
        exp_q.push_back({4'b1011, 2'b00, 3'b110});
        exp_lvl = 2'd1;
        sobe_req = 1'b1;
        @(negedge clock);
        sobe_req = 1'b0;
        n = 0;
        while (ocupado && n < 40) begin
            n++;
            @(negedge clock);
        end
        check("ocupado_cycles", 32'(n), 32'(1 + HOLD));
        check("nivel_after_sobe", 32'(nivel), 32'd1);

        // Saturation rejects, preset equal to level, simultaneous manual requests
        req(1'b1, 2'd3, 1'b0, 1'b0);
        req(1'b0, 2'd0, 1'b1, 1'b0);
        req(1'b1, 2'd0, 1'b0, 1'b0);
        req(1'b0, 2'd0, 1'b0, 1'b1);
        req(1'b1, 2'd0, 1'b0, 1'b0);
        req(1'b0, 2'd0, 1'b1, 1'b1);
        req(1'b1, 2'd2, 1'b1, 1'b0);

        // Emergency raised during HOLD at level 3
        wait_idle();
        exp_q.push_back({4'b1010, 2'd3, 3'b000});
        exp_lvl = 2'd3;
        preset_req = 1'b1; preset_val = 2'd3;
        @(negedge clock);
        preset_req = 1'b0; preset_val = 2'd0;
        n = 0;
        while (estado != 3'd3 && n < 10) begin @(negedge clock); n++; end
        check("reached_hold", 32'(estado), 32'd3);
        emerg_run(3, 1'b0);

        // Emergency dropped after the first step still lands
        req(1'b1, 2'd2, 1'b0, 1'b0);
        emerg_run(2, 1'b1);

        // Asynchronous reset in the middle of a descent wait
        req(1'b1, 2'd3, 1'b0, 1'b0);
        emerg = 1'b1;
        n = 0;
        while (estado != 3'd5 && n < 20) begin @(negedge clock); n++; end
        check("reached_espera", 32'(estado), 32'd5);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 32'(all_out), 32'(RESET_VEC));
        emerg = 1'b0;
        @(negedge clock);
        check("held_reset_outputs", 32'(all_out), 32'(RESET_VEC));
        reset = 1'b0;
        exp_lvl = 2'd0;
        @(negedge clock);
        check("idle_after_async_reset", 32'(estado), 32'd1);
        check("nivel_after_async_reset", 32'(nivel), 32'd0);

        // Randomized manual/preset traffic against the reference
        for (int i = 0; i < 40; i++) begin
            pv = 2'($urandom_range(0, 3));
            req(($urandom_range(0, 3) == 0), pv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
